// File: rtl/mem_bus_arbiter2_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package mem_bus_arbiter2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY0 = 2'd1,
        ST_BUSY1 = 2'd2
    } arb_state_t;

    localparam logic [1:0]  GRANT_M0          = 2'b01;
    localparam logic [1:0]  GRANT_M1          = 2'b10;
    localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Watchdog for the arbiter: counts BUSY cycles without a slave ack,
// flags a forced completion and keeps a saturating count of them.
module mem_arb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       busy,
    input  logic       s_ready,
    output logic       expire,
    output logic [7:0] timeout_count
);

    localparam int unsigned     WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            terminal;

    // A real ack on the terminal cycle wins, so expire needs s_ready low.
    assign terminal = busy && (wd_cnt == WD_LAST);
    assign expire   = terminal && !s_ready;

    // Count BUSY cycles; clear whenever the transaction ends or the bus is idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (!busy || s_ready || terminal) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    // Saturating tally of forced completions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_count <= 8'd0;
        end else if (expire && (timeout_count != 8'hFF)) begin
            timeout_count <= timeout_count + 8'd1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter2.sv
// Two-master arbiter in front of a single picorv32-native memory slave.
// m0 = CPU, m1 = DMAC. One transaction at a time, round-robin or fixed
// priority, with a watchdog that force-completes unacknowledged requests.
module mem_bus_arbiter2
    import mem_bus_arbiter2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = DEFAULT_ERR_RDATA,
    parameter bit          FIXED_PRIO     = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        timeout_pulse,
    output logic [7:0]  timeout_count
);

    arb_state_t  state_q, state_d;
    logic        rr_last_q;      // 0 = m0 was served last, 1 = m1
    logic        busy;
    logic        expire;
    logic        done;
    logic [31:0] resp_rdata;

    assign busy       = (state_q != ST_IDLE);
    assign done       = busy && (s_ready || expire);
    assign resp_rdata = s_ready ? s_rdata : ERR_RDATA;

    mem_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk           (clk),
        .rst           (rst),
        .busy          (busy),
        .s_ready       (s_ready),
        .expire        (expire),
        .timeout_count (timeout_count)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Remember who was served last; reset to m1 so m0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last_q <= 1'b1;
        end else if (done) begin
            rr_last_q <= (state_q == ST_BUSY1);
        end
    end

    // Next-state: arbitrate in IDLE, return to IDLE on ack or timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_valid && m1_valid) begin
                    state_d = (FIXED_PRIO || rr_last_q) ? ST_BUSY0 : ST_BUSY1;
                end else if (m0_valid) begin
                    state_d = ST_BUSY0;
                end else if (m1_valid) begin
                    state_d = ST_BUSY1;
                end
            end
            ST_BUSY0, ST_BUSY1: begin
                if (s_ready || expire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: forward the owner's request and route the response back to it.
    always_comb begin
        grant         = 2'b00;
        s_valid       = 1'b0;
        s_instr       = 1'b0;
        s_addr        = 32'd0;
        s_wdata       = 32'd0;
        s_wstrb       = 4'd0;
        m0_ready      = 1'b0;
        m0_rdata      = 32'd0;
        m1_ready      = 1'b0;
        m1_rdata      = 32'd0;
        timeout_pulse = expire;
        case (state_q)
            ST_BUSY0: begin
                grant    = GRANT_M0;
                s_valid  = 1'b1;
                s_instr  = m0_instr;
                s_addr   = m0_addr;
                s_wdata  = m0_wdata;
                s_wstrb  = m0_wstrb;
                m0_ready = done;
                m0_rdata = done ? resp_rdata : 32'd0;
            end
            ST_BUSY1: begin
                grant    = GRANT_M1;
                s_valid  = 1'b1;
                s_instr  = m1_instr;
                s_addr   = m1_addr;
                s_wdata  = m1_wdata;
                s_wstrb  = m1_wstrb;
                m1_ready = done;
                m1_rdata = done ? resp_rdata : 32'd0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter2.sv
// Bench for mem_bus_arbiter2: directed cycle table, a few hand sequences
// and a randomized run against a transaction-level reference model.
module tb_mem_bus_arbiter2;

    localparam int          T   = 8;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk, rst;
    logic        m0_valid, m0_instr, m1_valid, m1_instr;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;

    logic        m0_ready, m1_ready, s_valid, s_instr, timeout_pulse;
    logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  grant;
    logic [7:0]  timeout_count;

    logic        f_m0_ready, f_m1_ready, f_s_valid, f_s_instr, f_timeout_pulse;
    logic [31:0] f_m0_rdata, f_m1_rdata, f_s_addr, f_s_wdata;
    logic [3:0]  f_s_wstrb;
    logic [1:0]  f_grant;
    logic [7:0]  f_timeout_count;

    int errors = 0;
    int checks = 0;

    mem_bus_arbiter2 #(.TIMEOUT_CYCLES(T), .ERR_RDATA(ERR), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst(rst),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .timeout_pulse(timeout_pulse), .timeout_count(timeout_count)
    );

    mem_bus_arbiter2 #(.TIMEOUT_CYCLES(T), .ERR_RDATA(ERR), .FIXED_PRIO(1'b1)) dut_f (
        .clk(clk), .rst(rst),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(f_m0_ready), .m0_rdata(f_m0_rdata),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(f_m1_ready), .m1_rdata(f_m1_rdata),
        .s_valid(f_s_valid), .s_instr(f_s_instr), .s_addr(f_s_addr), .s_wdata(f_s_wdata),
        .s_wstrb(f_s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(f_grant), .timeout_pulse(f_timeout_pulse), .timeout_count(f_timeout_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rs, m0v, m1v, sr;
        logic [31:0] srd;
        logic [1:0]  g;
        logic        r0, r1;
        logic [31:0] rd0, rd1;
        logic        tp;
        logic [7:0]  tc;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rs, input logic m0v, input logic m1v, input logic sr,
                       input logic [31:0] srd, input logic [1:0] g, input logic r0,
                       input logic r1, input logic [31:0] rd0, input logic [31:0] rd1,
                       input logic tp, input logic [7:0] tc);
        vec_t v;
        v.rs = rs; v.m0v = m0v; v.m1v = m1v; v.sr = sr; v.srd = srd;
        v.g = g; v.r0 = r0; v.r1 = r1; v.rd0 = rd0; v.rd1 = rd1; v.tp = tp; v.tc = tc;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0; s_rdata = 32'd0;
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // reference model state (random phase)
    int          owner, age, rr_last, tcount;
    logic        mv[2], mins[2], done_k[2];
    logic [31:0] maddr[2], mwd[2];
    logic [3:0]  mws[2];

    initial begin
        rst = 1'b1;
        m0_valid = 0; m1_valid = 0; s_ready = 0; s_rdata = 0;
        m0_instr = 1'b1; m0_addr = 32'h100; m0_wdata = 32'd0; m0_wstrb = 4'h0;
        m1_instr = 1'b0; m1_addr = 32'h200; m1_wdata = 32'hA5A5A5A5; m1_wstrb = 4'hF;
        do_reset();

        // m0 read, slave acks on the third BUSY cycle
        add(0,0,0,0,0,          2'b00,0,0,0,0,0,0);
        add(0,1,0,0,0,          2'b00,0,0,0,0,0,0);
        add(0,1,0,0,0,          2'b01,0,0,0,0,0,0);
        add(0,1,0,0,0,          2'b01,0,0,0,0,0,0);
        add(0,1,0,1,32'h12345678,2'b01,1,0,32'h12345678,0,0,0);
        add(0,0,0,1,32'h99,     2'b00,0,0,0,0,0,0);
        add(0,0,0,0,0,          2'b00,0,0,0,0,0,0);
        // round-robin tie from reset: m0, m1, then m1 beats re-asserting m0
        add(1,0,0,0,0,          2'b00,0,0,0,0,0,0);
        add(0,1,1,0,0,          2'b00,0,0,0,0,0,0);
        add(0,1,1,1,32'h11111111,2'b01,1,0,32'h11111111,0,0,0);
        add(0,1,1,0,0,          2'b00,0,0,0,0,0,0);
        add(0,1,1,1,32'h22222222,2'b10,0,1,0,32'h22222222,0,0);
        add(0,1,0,0,0,          2'b00,0,0,0,0,0,0);
        add(0,1,0,1,32'h33333333,2'b01,1,0,32'h33333333,0,0,0);
        add(0,0,0,0,0,          2'b00,0,0,0,0,0,0);
        // m1 write never acked: forced completion on 8th BUSY cycle
        add(1,0,0,0,0,          2'b00,0,0,0,0,0,0);
        add(0,0,1,0,0,          2'b00,0,0,0,0,0,0);
        for (int i = 0; i < T-1; i++) add(0,0,1,0,0, 2'b10,0,0,0,0,0,0);
        add(0,0,1,0,0,          2'b10,0,1,0,ERR,1,0);
        add(0,0,0,0,0,          2'b00,0,0,0,0,0,1);
        add(0,1,0,0,0,          2'b00,0,0,0,0,0,1);
        add(0,1,0,1,32'h44444444,2'b01,1,0,32'h44444444,0,0,1);
        // ack on exactly the 8th BUSY cycle: normal completion
        add(0,0,1,0,0,          2'b00,0,0,0,0,0,1);
        for (int i = 0; i < T-1; i++) add(0,0,1,0,0, 2'b10,0,0,0,0,0,1);
        add(0,0,1,1,32'h55555555,2'b10,0,1,0,32'h55555555,0,1);
        add(0,0,0,0,0,          2'b00,0,0,0,0,0,1);

        foreach (tbl[i]) begin
            rst = tbl[i].rs; m0_valid = tbl[i].m0v; m1_valid = tbl[i].m1v;
            s_ready = tbl[i].sr; s_rdata = tbl[i].srd;
            @(negedge clk);
            chk($sformatf("tbl%0d_ctl", i),
                {grant, s_valid, m0_ready, m1_ready, timeout_pulse, timeout_count},
                {tbl[i].g, (tbl[i].g != 2'b00), tbl[i].r0, tbl[i].r1, tbl[i].tp, tbl[i].tc});
            if (tbl[i].r0 || !tbl[i].g[0]) chk($sformatf("tbl%0d_rd0", i), m0_rdata, tbl[i].rd0);
            if (tbl[i].r1 || !tbl[i].g[1]) chk($sformatf("tbl%0d_rd1", i), m1_rdata, tbl[i].rd1);
            if (tbl[i].g != 2'b00) begin
                chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].g[0] ? 32'h100 : 32'h200);
                chk($sformatf("tbl%0d_wr", i), {s_instr, s_wstrb, s_wdata},
                    tbl[i].g[0] ? {1'b1, 4'h0, 32'h0} : {1'b0, 4'hF, 32'hA5A5A5A5});
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;

        // fixed priority: m0 back-to-back, m1 starved while m0 is valid
        do_reset();
        m0_valid = 1; m1_valid = 1; s_ready = 1; s_rdata = 32'h77;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("fixed_grant", f_grant, (i % 2) ? 2'b01 : 2'b00);
            @(posedge clk); #1;
        end
        m0_valid = 0;
        @(negedge clk);
        chk("fixed_idle", f_grant, 2'b00);
        @(posedge clk); #1;
        @(negedge clk);
        chk("fixed_m1", {f_grant, f_m1_ready, f_m1_rdata}, {2'b10, 1'b1, 32'h77});
        @(posedge clk); #1;
        m1_valid = 0; s_ready = 0;

        // reset in the middle of BUSY0, then a pending m1 is served
        do_reset();
        m0_valid = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_pre_grant", grant, 2'b01);
        #2;
        s_ready = 1; rst = 1;
        #1;
        chk("rst_async", {s_valid, grant, m0_ready}, 4'b0000);
        @(posedge clk); #1;
        rst = 0; m0_valid = 0; m1_valid = 1; s_ready = 0;
        @(negedge clk);
        chk("rst_idle", grant, 2'b00);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_m1_first", {grant, s_valid}, 3'b101);
        s_ready = 1;
        @(posedge clk); #1;
        m1_valid = 0; s_ready = 0;

        // randomized run against the reference model
        do_reset();
        owner = -1; age = 0; rr_last = 1; tcount = 0;
        for (int k = 0; k < 2; k++) begin
            mv[k] = 0; done_k[k] = 0; mins[k] = 0; maddr[k] = 0; mwd[k] = 0; mws[k] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [1:0]  eg;
            logic        er[2];
            logic [31:0] erd[2];
            logic        etp;
            for (int k = 0; k < 2; k++) begin
                if (done_k[k]) mv[k] = 0;
                if (!mv[k] && $urandom_range(0, 2) == 0) begin
                    mv[k] = 1; mins[k] = 1'($urandom_range(0, 1));
                    maddr[k] = $urandom; mwd[k] = $urandom; mws[k] = 4'($urandom_range(0, 15));
                end
            end
            m0_valid = mv[0]; m0_instr = mins[0]; m0_addr = maddr[0]; m0_wdata = mwd[0]; m0_wstrb = mws[0];
            m1_valid = mv[1]; m1_instr = mins[1]; m1_addr = maddr[1]; m1_wdata = mwd[1]; m1_wstrb = mws[1];
            s_ready = ($urandom_range(0, 5) == 0);
            s_rdata = $urandom;

            @(negedge clk);
            eg = 2'b00; etp = 0;
            er[0] = 0; er[1] = 0; erd[0] = 0; erd[1] = 0;
            if (owner >= 0) begin
                eg = (owner == 0) ? 2'b01 : 2'b10;
                etp = !s_ready && (age == T - 1);
                er[owner] = s_ready || etp;
                erd[owner] = s_ready ? s_rdata : ERR;
            end
            chk("rand_ctl", {grant, s_valid, m0_ready, m1_ready, timeout_pulse, timeout_count},
                {eg, (owner >= 0), er[0], er[1], etp, 8'(tcount)});
            if (owner >= 0)
                chk("rand_fwd", {s_addr ^ s_wdata, s_wstrb, s_instr},
                    {maddr[owner] ^ mwd[owner], mws[owner], mins[owner]});
            for (int k = 0; k < 2; k++)
                if (er[k] || owner != k)
                    chk($sformatf("rand_rd%0d", k), (k == 0) ? m0_rdata : m1_rdata, erd[k]);

            if (owner < 0) begin
                if (mv[0] && mv[1]) owner = (rr_last == 0) ? 1 : 0;
                else if (mv[0]) owner = 0;
                else if (mv[1]) owner = 1;
                age = 0;
            end else if (er[owner]) begin
                rr_last = owner;
                if (etp && tcount < 255) tcount++;
                owner = -1;
                age = 0;
            end else begin
                age++;
            end
            done_k[0] = er[0]; done_k[1] = er[1];
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
